// File: rtl/dc_tag_hit_detect.sv
// dc_tag_hit_detect
// -----------------------------------------------------------------------------
// Data-cache tag lookup stage placed after the 4-way tag-bank read mux.
// Two-stage pipeline:
//   S1     : holds the accepted request (index, tag). The tag banks return
//            their data during this stage, and the compare is done here.
//   Output : registered hit / way / index result for the cache controller.
// Sustains one lookup per cycle when the consumer does not stall.
//
// Optional feature macro: DC_TAG_MULTIHIT_CHK_EN
//   defined   -> res_multihit port present; set when two or more ways match.
//   undefined -> port and popcount logic absent; way selection is unchanged.
//
// Ports
//   clk                 in   rising-edge clock
//   reset               in   synchronous active-high reset
//   req_valid           in   lookup request present
//   req_retry           out  request not accepted this cycle
//   req_index           in   set index        [IDX_W]
//   req_tag             in   tag to compare   [TAG_W]
//   rd_en               out  tag-bank read strobe (data returns next cycle)
//   rd_index            out  set index for the bank read [IDX_W]
//   bank0..3_tag        in   tag read from way 0..3 [TAG_W]
//   bank0..3_v          in   valid bit read from way 0..3
//   res_valid           out  result present
//   res_retry           in   consumer cannot take the result
//   res_hit             out  a valid way matched
//   res_way             out  matching way (lowest on multi-hit), 0 on miss
//   res_index           out  index of the lookup [IDX_W]
//   res_multihit        out  more than one way matched (macro builds only)
// -----------------------------------------------------------------------------
module dc_tag_hit_detect #(
  parameter int TAG_W = 18,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_retry,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rd_en,
  output logic [IDX_W-1:0] rd_index,
  input  logic [TAG_W-1:0] bank0_tag,
  input  logic [TAG_W-1:0] bank1_tag,
  input  logic [TAG_W-1:0] bank2_tag,
  input  logic [TAG_W-1:0] bank3_tag,
  input  logic             bank0_v,
  input  logic             bank1_v,
  input  logic             bank2_v,
  input  logic             bank3_v,
  output logic             res_valid,
  input  logic             res_retry,
  output logic             res_hit,
  output logic [1:0]       res_way,
  output logic [IDX_W-1:0] res_index
`ifdef DC_TAG_MULTIHIT_CHK_EN
  ,
  output logic             res_multihit
`endif
);

  // Lowest-numbered matching way wins; 0 when nothing matches.
  function automatic logic [1:0] first_way(input logic [3:0] m);
    logic [1:0] w;
    w = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) w = 2'(i);
    end
    return w;
  endfunction

`ifdef DC_TAG_MULTIHIT_CHK_EN
  function automatic logic two_or_more(input logic [3:0] m);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      cnt = cnt + {2'b00, m[i]};
    end
    return (cnt >= 3'd2);
  endfunction
`endif

  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_index_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             res_valid_q;
  logic             res_hit_q;
  logic [1:0]       res_way_q;
  logic [IDX_W-1:0] res_index_q;

  logic             stall;
  logic             accept;
  logic             s1_load;
  logic [3:0]       match;
  logic             hit_d;
  logic [1:0]       way_d;

  assign stall     = res_valid_q & res_retry;
  assign req_retry = reset | (s1_valid_q & stall);
  assign accept    = req_valid & ~req_retry;
  // S1 may still take one request while the output is stalled, as long as
  // S1 itself is empty.
  assign s1_load   = ~stall | ~s1_valid_q;

  // The replay read keeps bank data valid in every cycle S1 is occupied while
  // stalled, so the compare below always sees this entry's set.
  assign rd_en     = ~reset & (accept | (s1_valid_q & stall));
  assign rd_index  = accept ? req_index : s1_index_q;

  assign match[0]  = bank0_v & (bank0_tag == s1_tag_q);
  assign match[1]  = bank1_v & (bank1_tag == s1_tag_q);
  assign match[2]  = bank2_v & (bank2_tag == s1_tag_q);
  assign match[3]  = bank3_v & (bank3_tag == s1_tag_q);
  assign hit_d     = |match;
  assign way_d     = first_way(match);

  // ---- S1: request capture ----
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
    end else if (s1_load) begin
      s1_valid_q <= accept;
    end
  end

  always_ff @(posedge clk) begin
    if (s1_load && accept) begin
      s1_index_q <= req_index;
      s1_tag_q   <= req_tag;
    end
  end

  // ---- Output: registered compare result ----
  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_way_q   <= 2'd0;
      res_index_q <= '0;
    end else if (!stall) begin
      res_valid_q <= s1_valid_q;
      res_hit_q   <= hit_d;
      res_way_q   <= way_d;
      res_index_q <= s1_index_q;
    end
  end

`ifdef DC_TAG_MULTIHIT_CHK_EN
  logic res_multihit_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      res_multihit_q <= 1'b0;
    end else if (!stall) begin
      res_multihit_q <= two_or_more(match);
    end
  end

  assign res_multihit = res_multihit_q;
`endif

  assign res_valid = res_valid_q;
  assign res_hit   = res_hit_q;
  assign res_way   = res_way_q;
  assign res_index = res_index_q;

endmodule

// File: doc/dc_tag_hit_detect.md
# dc_tag_hit_detect

Data-cache tag lookup stage that sits directly downstream of the 4-way tag-bank read mux. It accepts a lookup request (set index plus tag), issues the read to all four tag banks, compares the returned tags against the request in the cycle they arrive, and delivers a registered hit/way result to the cache controller. The block is a 2-stage pipeline with valid/retry handshakes on both sides and sustains one lookup per cycle when the consumer does not stall.

## Interface
- TAG_W, 18, tag width in bits
- IDX_W, 7, set index width in bits
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  lookup request present
- req_retry  out  1  request not accepted this cycle
- req_index  in  IDX_W  set index
- req_tag  in  TAG_W  tag to compare
- rd_en  out  1  tag-bank read strobe; data returns the next cycle
- rd_index  out  IDX_W  set index for the bank read
- bank0_tag..bank3_tag  in  TAG_W each  tag read from way 0..3, valid the cycle after rd_en
- bank0_v..bank3_v  in  1 each  valid bit read from way 0..3
- res_valid  out  1  result present
- res_retry  in  1  consumer cannot take result
- res_hit  out  1  a valid way matched
- res_way  out  2  matching way (lowest on multi-hit), 0 on miss
- res_index  out  IDX_W  index of the lookup
- res_multihit  out  1  more than one way matched (only with DC_TAG_MULTIHIT_CHK_EN)

## Operation
- Accept: accept = req_valid & !req_retry. req_retry = reset | (s1_valid & res_valid & res_retry).
- Stage 1 (S1) holds s1_valid, s1_index, s1_tag. Stall = res_valid & res_retry. When !stall: s1_valid <= accept, s1_index/s1_tag <= request fields on accept. When stall: S1 holds.
- Read issue (combinational): rd_en = accept | (s1_valid & stall); rd_index = accept ? req_index : s1_index. The replay read while stalled keeps bank data valid in every cycle S1 is occupied.
- Compare (combinational, in S1): match[w] = bank_w_v & (bank_w_tag == s1_tag). hit = |match. way = priority encode, way 0 highest priority.
- Output register loads when !stall: res_valid <= s1_valid; res_hit, res_way, res_index, res_multihit <= S1 compare results. When S1 is empty, data fields are don't-care, but res_valid = 0.
- Index conflicts with writes are the controller's responsibility; this block does no forwarding.

## Timing
- Reset values: res_valid 0, res_hit 0, res_way 0, res_index 0, res_multihit 0, s1_valid 0. req_retry 1 while reset is high. rd_en 0 while reset is high.
- Latency: a request accepted in cycle N drives rd_en in N. Bank data is compared in N+1, and res_valid is high in N+2.
- Throughput: 1 per cycle with res_retry low.
- Backpressure: res_retry high with res_valid high holds all outputs stable. The cycle after res_retry falls, the held result is consumed.
- S1 full while stalled: req_retry is high and a replay rd_en uses s1_index each stalled cycle.
- Stall with S1 empty: requests are still accepted (1 entry), then req_retry rises.
- res_retry while res_valid is low is ignored.
- Reset mid-operation: in-flight S1 and output entries are dropped. There is no res_valid for them after reset.

## Configuration
- DC_TAG_MULTIHIT_CHK_EN defined: res_multihit port exists and is 1 when two or more ways match. It is registered with the result, and way selection is unchanged.
- Undefined: port absent and no popcount logic. Priority select is identical.

## Test plan
- Single hit: bank2_tag=0x1A5, bank2_v=1, others differ, req_tag=0x1A5, idx=0x13 at cycle N -> rd_en/rd_index=0x13 in N; cycle N+2: res_valid=1, hit=1, way=2, res_index=0x13.
- Miss via valid bit: all tags=0x0FF, all bankN_v=0, req_tag=0x0FF -> res_hit=0, res_way=0.
- Back-to-back with stall: requests idx 1,2,3 on consecutive cycles, res_retry=1 for 3 cycles from first res_valid -> req_retry high with S1 full, rd_index replays S1's index, results arrive in order 1,2,3 with none lost or duplicated.
- Multi-hit (macro on): ways 1 and 3 match -> way=1, res_multihit=1. Macro off -> way=1 and no port.
- Reset mid-stream: reset asserted 1 cycle while S1 and output are full -> res_valid=0 next cycle, req_retry=1 during reset and 0 after, with no stale result.
- Stall with S1 empty: res_retry=1 on a held result, one new request -> accepted. The second request sees req_retry=1.
